// File: rtl/symbol_ram_ctrl_pkg.sv
// Shared types for the symbol RAM controller: write FSM encoding, byte-lane width
// and the per-byte parity helper used when RCB_PARITY_EN is defined.
package tts_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_PEND = 2'd1,
        W_HOLD = 2'd2
    } wr_state_e;

    // Even parity: the stored bit makes the total count of ones in the byte even.
    function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/symbol_ram_ctrl_if.sv
// Host-facing bus of the symbol RAM controller (read channels + host write port).
// Optional macro RCB_PARITY_EN adds the per-channel rd_perr flag.
interface symbol_ram_ctrl_if #(
    parameter int RAM_WIDTH = 64,
    parameter int RAM_DEPTH = 16384,
    parameter int RD_CH     = 2
);
    localparam int AW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int BE_W = RAM_WIDTH / 8;

    logic [RD_CH-1:0]           rd_req;
    logic [RD_CH*AW-1:0]        rd_addr;
    logic [RD_CH-1:0]           rd_gnt;
    logic [RD_CH-1:0]           rd_valid;
    logic [RD_CH*RAM_WIDTH-1:0] rd_data;
    logic                       wr_req;
    logic [AW-1:0]              wr_addr;
    logic [RAM_WIDTH-1:0]       wr_data;
    logic [BE_W-1:0]            wr_be;
    logic                       wr_done;
`ifdef RCB_PARITY_EN
    logic [RD_CH-1:0]           rd_perr;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_gnt, rd_valid, rd_data, wr_done, rd_perr
    );
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_gnt, rd_valid, rd_data, wr_done, rd_perr
    );
`else
    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        input  rd_gnt, rd_valid, rd_data, wr_done
    );
    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_be,
        output rd_gnt, rd_valid, rd_data, wr_done
    );
`endif

endinterface

// File: rtl/symbol_ram_ctrl_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant, pointer moves one past the
// granted requester whenever advance is high.
module rcb_rr_arb #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_next_ptr;
    logic          w_found;

    // Pick the first requester at or after the pointer, walking in priority distance order.
    always_comb begin
        gnt        = '0;
        w_next_ptr = r_ptr;
        w_found    = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int c = 0; c < N; c++) begin
                if (!w_found && req[c] && (((c + N - int'(r_ptr)) % N) == i)) begin
                    gnt[c]     = 1'b1;
                    w_next_ptr = (c == N - 1) ? '0 : PW'(c + 1);
                    w_found    = 1'b1;
                end else begin
                    w_found = w_found;
                end
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= w_next_ptr;
        end
    end

endmodule

// File: rtl/symbol_ram_ctrl.sv
// Single-port symbol RAM shared by RD_CH round-robin read channels and one host
// write port with starvation-bounded priority. Optional macro: RCB_PARITY_EN.
module symbol_ram_ctrl #(
    parameter int RAM_WIDTH  = 64,
    parameter int RAM_DEPTH  = 16384,
    parameter int RD_CH      = 2,
    parameter int STARVE_MAX = 15
) (
    input  logic             clk,
    input  logic             reset_n,
    symbol_ram_ctrl_if.slave bus
);
    import tts_pkg::*;

    localparam int AW   = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int BE_W = RAM_WIDTH / BYTE_W;
`ifdef RCB_PARITY_EN
    localparam int MW = RAM_WIDTH + BE_W;
`else
    localparam int MW = RAM_WIDTH;
`endif
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    wr_state_e                  r_state;
    logic [7:0]                 r_starve;
    logic                       r_wr_done;
    logic                       w_force;
    logic                       w_wr_gnt;
    logic [RD_CH-1:0]           w_arb_gnt;
    logic [RD_CH-1:0]           w_rd_gnt;
    logic [RD_CH-1:0]           r_p1_valid;
    logic [RD_CH-1:0]           r_rd_valid;
    logic [RD_CH*RAM_WIDTH-1:0] r_rd_data;
    logic [AW-1:0]              w_rd_addr;
    logic [AW-1:0]              w_ram_addr;
    logic [MW-1:0]              r_mem [RAM_DEPTH];
    logic [MW-1:0]              r_ram_q;

    rcb_rr_arb #(.N(RD_CH)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.rd_req),
        .advance (|w_rd_gnt),
        .gnt     (w_arb_gnt)
    );

    // Port arbitration: forced write beats reads, reads beat a merely pending write.
    always_comb begin
        w_force  = (r_state == W_PEND) && (r_starve == STARVE_LIM);
        w_rd_gnt = (reset_n && !w_force) ? w_arb_gnt : '0;
        w_wr_gnt = reset_n && (r_state == W_PEND) && (w_force || !(|bus.rd_req));
    end

    // Address of the granted read channel, then the single RAM address.
    always_comb begin
        w_rd_addr = '0;
        for (int c = 0; c < RD_CH; c++) begin
            if (w_rd_gnt[c]) begin
                w_rd_addr = bus.rd_addr[c*AW +: AW];
            end else begin
                w_rd_addr = w_rd_addr;
            end
        end
        w_ram_addr = w_wr_gnt ? bus.wr_addr : w_rd_addr;
    end

    // Block RAM: byte-masked write or registered read, never both in one cycle; no reset.
    always_ff @(posedge clk) begin
        if (w_wr_gnt) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.wr_be[b]) begin
                    r_mem[w_ram_addr][b*BYTE_W +: BYTE_W] <= bus.wr_data[b*BYTE_W +: BYTE_W];
`ifdef RCB_PARITY_EN
                    r_mem[w_ram_addr][RAM_WIDTH+b] <= byte_parity(bus.wr_data[b*BYTE_W +: BYTE_W]);
`endif
                end
            end
        end
        if (|w_rd_gnt) begin
            r_ram_q <= r_mem[w_ram_addr];
        end
    end

`ifdef RCB_PARITY_EN
    logic             w_q_perr;
    logic [RD_CH-1:0] r_rd_perr;

    // Any byte of the RAM output whose stored parity disagrees.
    always_comb begin
        w_q_perr = 1'b0;
        for (int b = 0; b < BE_W; b++) begin
            if (byte_parity(r_ram_q[b*BYTE_W +: BYTE_W]) != r_ram_q[RAM_WIDTH+b]) begin
                w_q_perr = 1'b1;
            end else begin
                w_q_perr = w_q_perr;
            end
        end
    end

    // Parity flag travels with rd_valid.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_perr <= '0;
        end else begin
            r_rd_perr <= r_p1_valid & {RD_CH{w_q_perr}};
        end
    end

    assign bus.rd_perr = r_rd_perr;
`endif

    // Read return pipeline: RAM output stage, then per-channel holding registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_p1_valid <= '0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            r_p1_valid <= w_rd_gnt;
            r_rd_valid <= r_p1_valid;
            for (int c = 0; c < RD_CH; c++) begin
                if (r_p1_valid[c]) begin
                    r_rd_data[c*RAM_WIDTH +: RAM_WIDTH] <= r_ram_q[RAM_WIDTH-1:0];
                end
            end
        end
    end

    // Host write FSM with starvation counter; HOLD waits for wr_req to drop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= W_IDLE;
            r_starve  <= 8'd0;
            r_wr_done <= 1'b0;
        end else begin
            r_wr_done <= w_wr_gnt;
            case (r_state)
                W_IDLE: begin
                    r_starve <= 8'd0;
                    if (bus.wr_req) begin
                        r_state <= W_PEND;
                    end
                end
                W_PEND: begin
                    if (w_wr_gnt) begin
                        r_state  <= W_HOLD;
                        r_starve <= 8'd0;
                    end else if (r_starve != STARVE_LIM) begin
                        r_starve <= r_starve + 8'd1;
                    end
                end
                W_HOLD: begin
                    r_starve <= 8'd0;
                    if (!bus.wr_req) begin
                        r_state <= W_IDLE;
                    end
                end
                default: begin
                    r_state  <= W_IDLE;
                    r_starve <= 8'd0;
                end
            endcase
        end
    end

    assign bus.rd_gnt   = w_rd_gnt;
    assign bus.rd_valid = r_rd_valid;
    assign bus.rd_data  = r_rd_data;
    assign bus.wr_done  = r_wr_done;

endmodule

// File: tb/tb_symbol_ram_ctrl.sv
// Scoreboard bench for symbol_ram_ctrl (RD_CH=2, STARVE_MAX=3): expected reads are
// queued at grant time from a reference memory and compared when rd_valid arrives.
module tb_symbol_ram_ctrl;

    localparam int AW = 14;
    localparam int W  = 64;

    logic clk;
    logic reset_n;
    int   cyc;
    int   n_chk;
    int   n_err;

    symbol_ram_ctrl_if #(.RAM_WIDTH(W), .RAM_DEPTH(16384), .RD_CH(2)) bus ();

    symbol_ram_ctrl #(
        .RAM_WIDTH  (W),
        .RAM_DEPTH  (16384),
        .RD_CH      (2),
        .STARVE_MAX (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        int          due;
        int          ch;
        logic [63:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] model_mem [bit [13:0]];
    logic [63:0] last_data [2];
    logic        wr_pend;
    logic [13:0] tb_wr_addr;
    logic [63:0] tb_wr_data;
    logic [7:0]  tb_wr_be;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor / scoreboard, sampled on the falling edge.
    initial begin : mon
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.wr_done) begin
                check_eq("wr_done_expected", 64'(wr_pend), 64'd1);
                if (wr_pend) begin
                    for (int b = 0; b < 8; b++) begin
                        if (tb_wr_be[b]) model_mem[tb_wr_addr][b*8 +: 8] = tb_wr_data[b*8 +: 8];
                    end
                end
                wr_pend = 1'b0;
            end
            if (bus.rd_gnt != 2'b00) begin
                check_eq("gnt_onehot", 64'($onehot(bus.rd_gnt)), 64'd1);
                check_eq("gnt_subset", 64'(bus.rd_gnt & ~bus.rd_req), 64'd0);
            end
            for (int c = 0; c < 2; c++) begin
                if (bus.rd_valid[c]) begin
                    if (sb_q.size() == 0) begin
                        check_eq("rd_unexpected", 64'(bus.rd_valid[c]), 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("rd_ch", 64'(c), 64'(e.ch));
                        check_eq("rd_latency", 64'(cyc), 64'(e.due));
                        check_eq("rd_data", bus.rd_data[c*W +: W], e.data);
                    end
                    last_data[c] = bus.rd_data[c*W +: W];
                end else if (bus.rd_data[c*W +: W] !== last_data[c]) begin
                    check_eq("rd_data_hold", bus.rd_data[c*W +: W], last_data[c]);
                end
            end
            if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                check_eq("rd_missing", 64'd0, 64'd1);
                void'(sb_q.pop_front());
            end
            for (int c = 0; c < 2; c++) begin
                if (bus.rd_gnt[c]) begin
                    e.due  = cyc + 2;
                    e.ch   = c;
                    e.data = model_mem[bus.rd_addr[c*AW +: AW]];
                    sb_q.push_back(e);
                end
            end
            if (!reset_n) begin
                sb_q.delete();
                wr_pend      = 1'b0;
                last_data[0] = '0;
                last_data[1] = '0;
            end
        end
    end

    task automatic do_write(input logic [13:0] a, input logic [63:0] d, input logic [7:0] be,
                            input int exp_lat, input int hold);
        int lat;
        tb_wr_addr  = a;
        tb_wr_data  = d;
        tb_wr_be    = be;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_be   = be;
        bus.wr_req  = 1'b1;
        wr_pend     = 1'b1;
        lat = -1;
        for (int n = 0; n < 30 && lat < 0; n++) begin
            @(negedge clk);
            if (bus.wr_done) lat = n;
        end
        check_eq("wr_latency", 64'(lat), 64'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("wr_no_repeat", 64'(bus.wr_done), 64'd0);
        end
        tick();
        bus.wr_req = 1'b0;
        tick();
    endtask

    task automatic do_read(input int ch, input logic [13:0] a);
        logic [1:0] eg;
        eg = 2'b00;
        eg[ch] = 1'b1;
        bus.rd_addr[ch*AW +: AW] = a;
        bus.rd_req = eg;
        @(negedge clk);
        check_eq("rd_gnt_single", 64'(bus.rd_gnt), 64'(eg));
        tick();
        bus.rd_req = 2'b00;
        repeat (3) tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : main
        cyc = 0; n_chk = 0; n_err = 0; wr_pend = 1'b0;
        last_data[0] = '0; last_data[1] = '0;
        reset_n = 1'b0;
        bus.rd_req = 2'b00; bus.rd_addr = '0;
        bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_be = '0;
        repeat (3) tick();
        @(negedge clk);
        check_eq("rst_rd_gnt", 64'(bus.rd_gnt), 64'd0);
        check_eq("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        check_eq("rst_rd_data", bus.rd_data[63:0] | bus.rd_data[127:64], 64'd0);
        check_eq("rst_wr_done", 64'(bus.wr_done), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // Basic write then read back
        do_write(14'h0010, 64'h1122334455667788, 8'hFF, 2, 0);
        do_read(0, 14'h0010);

        // Byte lanes and zero byte-enable
        do_write(14'h0005, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 2, 0);
        do_write(14'h0005, 64'h0000000000000000, 8'h0F, 2, 0);
        do_read(1, 14'h0005);
        do_write(14'h0005, 64'hDEADBEEFCAFEF00D, 8'h00, 2, 0);
        do_read(0, 14'h0005);

        // Round robin from a fresh pointer
        reset_n = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        bus.rd_addr = {14'h0005, 14'h0010};
        bus.rd_req  = 2'b11;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("rr_gnt", 64'(bus.rd_gnt), (i % 2 == 0) ? 64'd1 : 64'd2);
            tick();
        end
        bus.rd_req = 2'b00;
        repeat (3) tick();

        // Starvation: write forced on the 4th pending cycle
        bus.rd_req = 2'b11;
        tb_wr_addr = 14'h0020; tb_wr_data = 64'h0123456789ABCDEF; tb_wr_be = 8'hFF;
        bus.wr_addr = tb_wr_addr; bus.wr_data = tb_wr_data; bus.wr_be = tb_wr_be;
        bus.wr_req = 1'b1;
        wr_pend    = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n < 4) check_eq("starve_rd_gnt", 64'(|bus.rd_gnt), 64'd1);
            if (n == 4) check_eq("forced_rd_gnt", 64'(bus.rd_gnt), 64'd0);
            check_eq("starve_wr_done", 64'(bus.wr_done), (n == 5) ? 64'd1 : 64'd0);
        end
        tick();
        bus.wr_req = 1'b0;
        bus.rd_req = 2'b00;
        repeat (3) tick();
        do_read(1, 14'h0020);

        // Held wr_req gives one write only; a 1-cycle drop allows the next
        do_write(14'h0030, 64'hAAAA5555AAAA5555, 8'hFF, 2, 5);
        do_write(14'h0030, 64'h0F0F0F0F12345678, 8'hFF, 2, 0);
        do_read(0, 14'h0030);

        // Reset while the write is pending behind reads
        bus.rd_addr = {14'h0005, 14'h0010};
        bus.rd_req  = 2'b11;
        tb_wr_addr = 14'h0010; tb_wr_data = 64'hBADBADBADBADBAD0; tb_wr_be = 8'hFF;
        bus.wr_addr = tb_wr_addr; bus.wr_data = tb_wr_data; bus.wr_be = tb_wr_be;
        bus.wr_req = 1'b1;
        wr_pend    = 1'b1;
        tick();
        tick();
        reset_n = 1'b0;
        tick();
        bus.rd_req = 2'b00;
        bus.wr_req = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check_eq("post_rst_wr_done", 64'(bus.wr_done), 64'd0);
            check_eq("post_rst_rd_valid", 64'(bus.rd_valid), 64'd0);
        end
        tick();
        do_read(0, 14'h0010);
        do_read(1, 14'h0005);
        do_write(14'h0040, 64'h8877665544332211, 8'hFF, 2, 0);
        do_read(1, 14'h0040);

        repeat (4) tick();
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
